avst_pkt_arbiter: RTL and testbench
===================================

# avst_pkt_arbiter

Packet-granular round-robin arbiter that merges NUM_IN Avalon-ST packet streams (e.g. several pcapreader64 sources) onto one `avalonST` output feeding the packet parser. A grant is held from the SOP beat to the EOP beat, so packets are never interleaved. The output is fully registered. Per-input packet counters support bench and debug visibility.

## Interface
- `DATA_WIDTH`, default 64: beat width in bits; must be a multiple of 8; `EMPTY_W = $clog2(DATA_WIDTH/8)`.
- `NUM_IN`, default 4: number of input streams, 2..8.
- `CNT_W`, default 32: width of each per-input packet counter.
- `clk` input, 1 bit: single clock for all logic.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `in[NUM_IN]` avalonST slave, `DATA_WIDTH`: input streams with valid, ready, sop, eop, empty, data.
- `out` avalonST master, `DATA_WIDTH`: merged output stream.
- `o_grant` output, `NUM_IN` bits: one-hot grant of the current owner; all zeros when no input owns the output.
- `o_busy` output, 1 bit: high while in state BUSY.
- `o_pkt_count[NUM_IN]` output, `CNT_W` bits each: number of EOP beats accepted per input; wraps to 0.

## Operation
- **States**
  - ARB: no owner; `in[*].ready` = 0.
  - BUSY: one owner; beats from the owner are forwarded.
- **ARB to BUSY**
  - A request is `in[i].valid && in[i].sop`.
  - The winner is the first requesting index scanning upward from `(last + 1) mod NUM_IN`.
  - The winner's bit is registered into `o_grant`, `last` is updated to the winner, and the state moves to BUSY.
  - With no request, the block stays in ARB.
- **Non-SOP heads in ARB**: an input presenting valid without sop in ARB does not request. Its ready stays 0, so it stalls indefinitely; this is the intended behaviour for a malformed source.
- **BUSY**
  - Owner ready: `in[g].ready = !out_valid_q || out.ready`. Every other input's ready = 0.
  - Accept condition: `in[g].valid && in[g].ready`.
  - On accept, data, sop, eop and empty are copied into the output register and `out_valid_q` is set.
  - A sop inside a packet (missing EOP) is forwarded unchanged and does not release the grant.
- **BUSY to ARB**
  - On an accepted beat with eop = 1, the state returns to ARB, `o_grant` clears, and `o_pkt_count[g]` increments.
  - A single-beat packet (sop = eop = 1) goes ARB → BUSY → ARB with one accepted beat.
- **Output register**
  - When `out.ready && out_valid_q` with no new accept, `out.valid` drops next cycle.
  - Simultaneous drain and accept loads the new beat with valid held at 1.
  - While `out.valid` = 1 and `out.ready` = 0, all output fields are held stable.
- **Reset** (asynchronous, any state, including mid-packet)
  - State goes to ARB, `last` = NUM_IN−1 so that input 0 has first priority, and `o_grant` = 0.
  - All out fields go to 0: valid, sop, eop, empty, data.
  - All counters go to 0.
  - A packet truncated by reset is not completed.

## Timing
- Arbitration costs exactly one cycle: the grant registers at the edge ending the ARB cycle, and the first beat is accepted in the following cycle.
- A beat accepted at edge k appears on `out` after edge k (1-cycle latency).
- Back-to-back packets therefore carry one bubble cycle between an EOP beat and the next SOP beat on `out`.
- Full throughput inside a packet with `out.ready` = 1: one beat per cycle.
- `o_grant`, `o_busy` and `o_pkt_count` are registered and update on the same edge as the state change or EOP accept.

## Structure
- Shared package `avst_arb_pkg` holds:
  - the `arb_state_t` enum {ARB, BUSY};
  - the `EMPTY_W` function;
  - the max-NUM_IN constant.
- One sub-module, `rr_pick`: purely combinational. It takes a request vector and `last`, and returns a one-hot winner and its index. It is reusable by other arbiters in the design.
- Everything else lives in `avst_pkt_arbiter`: the FSM, the output register and the counters.

## Test plan
- **Single-source pass-through**: after reset, input 0 sends a 3-beat packet (data 0x11, 0x22, 0x33; empty 5 on the last beat).
  - Expect `o_grant` = 0001 one cycle after SOP is first presented.
  - `out` shows the 3 beats on consecutive cycles, with sop on the first beat and eop plus empty = 5 on the last.
  - `o_pkt_count[0]` = 1.
- **Round-robin fairness**: all 4 inputs hold 2-beat packets continuously.
  - The grant sequence is 0, 1, 2, 3, 0, …
  - After 8 packets, every counter = 2, with exactly one bubble between packets on `out`.
- **No interleave under contention**: input 2 is in a 10-beat packet when input 1 raises SOP.
  - `in[1].ready` stays 0 until input 2's EOP is accepted.
  - Input 1 is granted in the next ARB cycle.
- **Backpressure**: `out.ready` toggles 1, 0, 0, 1 during a 4-beat packet.
  - `out` fields stay constant while stalled.
  - No beat is lost or duplicated; the owner's ready is low while the output register is full and stalled.
- **Single-beat and malformed heads**:
  - A sop = eop = 1 packet on input 3 increments `o_pkt_count[3]` to 1 and returns to ARB.
  - Input 0 holding valid = 1, sop = 0 in ARB is never granted, and its ready remains 0.
- **Reset mid-packet**: assert reset for 2 cycles during beat 2 of a 5-beat packet.
  - `out.valid`, `o_grant`, `o_busy` and all counters read 0 immediately.
  - After release, with inputs 0 and 1 requesting simultaneously, input 0 wins.

Source files
------------

// File: rtl/avst_arb_pkg.sv
// Types and helpers shared by the packet arbiter and any other arbiters
// built from rr_pick.
package avst_arb_pkg;

  localparam int MAX_NUM_IN = 8;

  typedef enum logic {
    ARB  = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of the Avalon-ST empty field. Kept to at least one bit so the
  // port stays legal for a single-byte bus.
  function automatic int empty_w(input int data_width);
    int w;
    w = $clog2(data_width / 8);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/avst_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from
// last+1 (mod N), returned both one-hot and as an index.
module rr_pick #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last) + k) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avst_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_IN Avalon-ST streams onto one
// fully registered output; a grant is held from SOP to EOP.
module avst_pkt_arbiter
  import avst_arb_pkg::*;
#(
  parameter int  DATA_WIDTH = 64,
  parameter int  NUM_IN     = 4,
  parameter int  CNT_W      = 32,
  localparam int EMPTY_W    = empty_w(DATA_WIDTH),
  localparam int IW         = $clog2(NUM_IN)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_IN-1:0]                   in_valid,
  output logic [NUM_IN-1:0]                   in_ready,
  input  logic [NUM_IN-1:0]                   in_sop,
  input  logic [NUM_IN-1:0]                   in_eop,
  input  logic [NUM_IN-1:0][EMPTY_W-1:0]      in_empty,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_sop,
  output logic                                out_eop,
  output logic [EMPTY_W-1:0]                  out_empty,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [NUM_IN-1:0]                   o_grant,
  output logic                                o_busy,
  output logic [NUM_IN-1:0][CNT_W-1:0]        o_pkt_count,
  output arb_state_t                          o_state
);

  arb_state_t        state_q;
  logic [IW-1:0]     last_q;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              accept;

  // Only a valid SOP head may win arbitration; a non-SOP head never requests.
  assign req = in_valid & in_sop;

  rr_pick #(.N(NUM_IN)) u_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Handshakes: a beat moves on a port only in a cycle where valid and ready
  // are both high at the clock edge. Ready never depends on the same port's
  // valid; the owner is ready whenever the output register is empty or drains.
  always_comb begin
    in_ready = '0;
    if (state_q == BUSY) begin
      in_ready = o_grant & {NUM_IN{!out_valid || out_ready}};
    end
  end

  assign accept  = |(in_valid & in_ready);
  assign o_busy  = (state_q == BUSY);
  assign o_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB;
      last_q      <= IW'(NUM_IN - 1);
      o_grant     <= '0;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_empty   <= '0;
      out_data    <= '0;
      o_pkt_count <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state_q)
        ARB: begin
          if (pick_any) begin
            state_q <= BUSY;
            o_grant <= pick_grant;
            last_q  <= pick_idx;
          end
        end
        BUSY: begin
          // last_q holds the current owner's index for the whole packet.
          if (accept) begin
            out_valid <= 1'b1;
            out_sop   <= in_sop[last_q];
            out_eop   <= in_eop[last_q];
            out_empty <= in_empty[last_q];
            out_data  <= in_data[last_q];
            if (in_eop[last_q]) begin
              state_q             <= ARB;
              o_grant             <= '0;
              o_pkt_count[last_q] <= o_pkt_count[last_q] + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avst_pkt_arbiter.sv
// Randomized scoreboard bench for avst_pkt_arbiter with a packet-level
// round-robin reference model.
module tb_avst_pkt_arbiter;
  import avst_arb_pkg::*;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int EW = 3;
  localparam int BW = DW + EW + 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [N-1:0]          in_valid, in_ready, in_sop, in_eop;
  logic [N-1:0][EW-1:0]  in_empty;
  logic [N-1:0][DW-1:0]  in_data;
  logic                  out_valid, out_ready, out_sop, out_eop;
  logic [EW-1:0]         out_empty;
  logic [DW-1:0]         out_data;
  logic [N-1:0]          o_grant;
  logic                  o_busy;
  logic [N-1:0][CW-1:0]  o_pkt_count;
  arb_state_t            o_state;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] exp_q[$];
  logic [N-1:0]  exp_g_q[$];
  logic [BW-1:0] src_q[N][$];
  logic [BW-1:0] mdl_q[N][$];
  int            cnt_exp[N];
  int            acc_cnt[N];
  int            mdl_last = N - 1;
  bit            gap_en = 0, rdy_rand = 0, rdy_force = 1, bubble_chk = 0;
  logic [N-1:0]  acc;

  avst_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_data(out_data),
    .o_grant(o_grant), .o_busy(o_busy), .o_pkt_count(o_pkt_count), .o_state(o_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input bit s, input bit e, input logic [EW-1:0] em,
                                       input logic [DW-1:0] d);
    return {s, e, em, d};
  endfunction

  // Queue one packet on input i for the driver and for the reference model.
  task automatic add_pkt(input int i, input int len, input logic [DW-1:0] d0,
                         input logic [EW-1:0] last_empty, input bit rnd);
    logic [DW-1:0] d;
    logic [BW-1:0] b;
    for (int k = 0; k < len; k++) begin
      d = rnd ? {$urandom, $urandom} : d0 * DW'(k + 1);
      b = mk(k == 0, k == len - 1, (k == len - 1) ? last_empty : '0, d);
      src_q[i].push_back(b);
      mdl_q[i].push_back(b);
    end
  endtask

  // Reference: every input with a pending packet is requesting; the next owner
  // is the first non-empty input after the previous owner, whole packets only.
  task automatic model_run();
    int w;
    bit found;
    logic [BW-1:0] b;
    logic [N-1:0] g;
    while (1) begin
      found = 0;
      w = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && mdl_q[(mdl_last + k) % N].size() > 0) begin
          found = 1;
          w = (mdl_last + k) % N;
        end
      end
      if (!found) break;
      g = '0;
      g[w] = 1'b1;
      exp_g_q.push_back(g);
      do begin
        b = mdl_q[w].pop_front();
        exp_q.push_back(b);
      end while (!b[BW-2]);
      cnt_exp[w]++;
      mdl_last = w;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    bit busy;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      busy = (exp_q.size() != 0) || o_busy || out_valid;
      for (int i = 0; i < N; i++) busy |= (src_q[i].size() != 0);
    end while (busy && t < budget);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d beats still expected", exp_q.size());
    end
    chk("grant queue drained", exp_g_q.size(), 0);
    for (int i = 0; i < N; i++) chk($sformatf("pkt_count[%0d]", i), o_pkt_count[i], cnt_exp[i]);
  endtask

  // ---------------- drivers ----------------
  initial begin
    logic [BW-1:0] h;
    in_valid = '0; in_sop = '0; in_eop = '0; in_empty = '0; in_data = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && reset && src_q[i].size() > 0) begin
          h = src_q[i].pop_front();
          acc_cnt[i]++;
        end
        if (src_q[i].size() > 0) begin
          h = src_q[i][0];
          in_sop[i]   = h[BW-1];
          in_eop[i]   = h[BW-2];
          in_empty[i] = h[DW +: EW];
          in_data[i]  = h[DW-1:0];
          in_valid[i] = h[BW-1] || !gap_en || ($urandom_range(0, 3) != 0);
        end else begin
          in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
          in_empty[i] = '0;   in_data[i] = '0;
        end
      end
      out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_force;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [BW-1:0] cur, prev;
  logic [N-1:0]  prev_g = '0;
  bit            prev_stall = 0, seen_eop = 0;
  int            idle = 0;

  initial begin
    forever begin
      @(negedge clk);
      cur = {out_sop, out_eop, out_empty, out_data};
      if (!reset) begin
        prev_stall = 0;
        seen_eop   = 0;
        prev_g     = '0;
      end else begin
        if (o_grant != '0 && prev_g == '0) begin
          if (exp_g_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected grant: got %b expected none", o_grant);
          end else begin
            chk("grant order", o_grant, exp_g_q.pop_front());
          end
        end
        prev_g = o_grant;
        chk("ready only to owner", in_ready & ~o_grant, 0);
        chk("grant onehot0", $onehot0(o_grant), 1);
        chk("busy vs grant", o_busy, o_grant != '0);
        chk("busy vs state", o_busy, o_state == BUSY);
        if (out_valid && !out_ready) chk("owner ready while stalled", in_ready, 0);
        if (prev_stall) chk("stall hold", {out_valid, cur}, {1'b1, prev});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected beat: got %0h expected none", cur);
          end else begin
            chk("out beat", cur, exp_q.pop_front());
          end
          if (bubble_chk && out_sop && seen_eop) chk("one bubble", idle, 1);
          if (out_eop) begin
            seen_eop = 1;
            idle = 0;
          end
        end else if (!out_valid) begin
          idle++;
        end
        if (!bubble_chk) seen_eop = 0;
        prev_stall = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    int t, leak, bad;
    logic [N-1:0][CW-1:0] base;
    for (int i = 0; i < N; i++) cnt_exp[i] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset grant", o_grant, 0);
    chk("reset busy", o_busy, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset counters", o_pkt_count, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single-source pass-through
    add_pkt(0, 3, 64'h11, 3'd5, 0);
    model_run();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t1 grant", o_grant, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1 consecutive", out_valid, 1);
    end
    wait_idle(100);
    chk("t1 count0", o_pkt_count[0], 1);

    // round-robin fairness, no gaps, one bubble between packets
    base = o_pkt_count;
    bubble_chk = 1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) add_pkt(i, 2, 0, 3'($urandom_range(0, 7)), 1);
    model_run();
    wait_idle(300);
    bubble_chk = 0;
    for (int i = 0; i < N; i++) chk("t2 two each", o_pkt_count[i] - base[i], 2);

    // no interleave under contention
    add_pkt(2, 10, 0, 3'd1, 1);
    model_run();
    t = 0;
    while (o_grant != 4'b0100 && t < 100) begin @(negedge clk); t++; end
    chk("t3 grant2", o_grant, 4'b0100);
    repeat (3) @(negedge clk);
    add_pkt(1, 3, 0, 3'd2, 1);
    model_run();
    leak = 0;
    t = 0;
    while (!(in_valid[2] && in_ready[2] && in_eop[2]) && t < 100) begin
      @(negedge clk);
      t++;
      if (in_ready[1]) leak++;
    end
    chk("t3 eop2 reached", in_valid[2] && in_ready[2] && in_eop[2], 1);
    chk("t3 no early ready1", leak, 0);
    @(negedge clk);
    chk("t3 arb cycle", o_grant, 0);
    @(negedge clk);
    chk("t3 grant1", o_grant, 4'b0010);
    wait_idle(100);

    // backpressure 1,0,0,1 during a 4-beat packet
    add_pkt(3, 4, 0, 3'd3, 1);
    model_run();
    t = 0;
    while (!(out_valid && out_sop) && t < 100) begin @(negedge clk); t++; end
    chk("t4 sop seen", out_valid && out_sop, 1);
    rdy_force = 0;
    @(negedge clk);
    chk("t4 stalled owner ready a", in_ready, 0);
    @(negedge clk);
    chk("t4 stalled owner ready b", in_ready, 0);
    rdy_force = 1;
    wait_idle(100);

    // reset in the middle of a 5-beat packet
    add_pkt(2, 5, 0, 3'd0, 1);
    model_run();
    t = acc_cnt[2];
    while (acc_cnt[2] < t + 2 && acc_cnt[2] >= t && t < 1000000) begin
      @(negedge clk);
      if (acc_cnt[2] == t + 2) break;
      if (($time / 10) > 100000) break;
    end
    chk("t6 two beats in", acc_cnt[2] - t, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6 out_valid", out_valid, 0);
    chk("t6 grant", o_grant, 0);
    chk("t6 busy", o_busy, 0);
    chk("t6 counters", o_pkt_count, 0);
    exp_q.delete();
    exp_g_q.delete();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
      cnt_exp[i] = 0;
    end
    mdl_last = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // inputs 0 and 1 request together after reset
    add_pkt(0, 2, 0, 3'd4, 1);
    add_pkt(1, 2, 0, 3'd6, 1);
    model_run();
    t = 0;
    while (o_grant == '0 && t < 100) begin @(negedge clk); t++; end
    chk("t7 input0 wins", o_grant, 4'b0001);
    wait_idle(100);

    // single-beat packet on input 3
    add_pkt(3, 1, 0, 3'd7, 1);
    model_run();
    wait_idle(100);
    chk("t5 single count3", o_pkt_count[3], 1);
    chk("t5 back to arb", o_busy, 0);

    // malformed head on input 0 never wins
    src_q[0].push_back(mk(0, 0, '0, 64'hBAD));
    add_pkt(1, 2, 0, 3'd0, 1);
    model_run();
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (in_ready[0] || o_grant[0]) bad++;
    end
    chk("t5 malformed presented", in_valid[0] && !in_sop[0], 1);
    chk("t5 malformed ignored", bad, 0);
    src_q[0].delete();
    wait_idle(100);

    // randomized rounds with source gaps and output backpressure
    gap_en = 1;
    rdy_rand = 1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        t = $urandom_range(0, 3);
        for (int p = 0; p < t; p++) add_pkt(i, $urandom_range(1, 6), 0, 3'($urandom_range(0, 7)), 1);
      end
      model_run();
      wait_idle(2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
